control_pipe: RTL and testbench
===============================

Name: control_pipe

Overview:
Registered successor to the main control decoder. It decodes opcode and funct7 in ID, drives a registered control bundle into the ID/EX boundary, inserts bubbles on load-use hazard or flush, and flags illegal opcodes. It also sequences multi-cycle M-extension ops with a busy state machine that stalls the front end for a parametrised latency.

Parameters:
MULDIV_LAT, 4, EX cycles occupied by a mul/div op; legal range 1..16; 1 = single-cycle, no stall.
CNT_W, 4, width of the busy countdown; must satisfy 2^CNT_W >= MULDIV_LAT.

Ports:
clk_i  in  1  clock; all state updates on rising edge.
rst_i  in  1  synchronous reset, active-low.
Valid_i  in  1  IF/ID holds a real instruction.
Op_i  in  7  opcode, instr[6:0].
Funct7_i  in  7  instr[31:25].
Hazard_i  in  1  load-use hazard from hazard unit; bubble this cycle.
Flush_i  in  1  branch/jump taken in EX; kill ID and abort busy.
RegWrite_o  out  1  registered control bundle to ID/EX (this and following to ALUSrc_o).
MemtoReg_o  out  1
MemRead_o  out  1
MemWrite_o  out  1
ALUOp_o  out  2  00 add, 01 R-type, 10 I-type arith, 11 branch compare.
ALUSrc_o  out  1
Branch_o  out  1
Jump_o  out  1  JAL/JALR.
MulDiv_o  out  1  issued op is M-extension.
Valid_o  out  1  bundle is a real instruction; 0 = bubble.
Stall_o  out  1  combinational from state; holds PC and IF/ID while busy.
Illegal_o  out  1  registered one-cycle pulse on an unknown opcode.

Behaviour:
- Reset (rst_i=0 at edge): all registered outputs 0; state IDLE; counter 0; Stall_o 0.
- Latency: decode is registered; the bundle appears one cycle after the ID inputs.
- Bubble: all bundle bits, Valid_o, MulDiv_o and Illegal_o are 0.
- Issue condition: state IDLE, Valid_i=1, Hazard_i=0, Flush_i=0. Any other case registers a bubble.
- Decode table (RW/M2R/MR/MW/ALUOp/ALUSrc/Br/J):
  - 0110011 R: 1/0/0/0/01/0/0/0
  - 0010011 I: 1/0/0/0/10/1/0/0
  - 0000011 LOAD: 1/1/1/0/00/1/0/0
  - 0100011 STORE: 0/0/0/1/00/1/0/0
  - 1100011 BRANCH: 0/0/0/0/11/0/1/0
  - 1101111 JAL and 1100111 JALR: 1/0/0/0/00/1/0/1
  - 0110111 LUI and 0010111 AUIPC: 1/0/0/0/00/1/0/0
- Unknown opcode that meets the issue condition: register a bubble and set Illegal_o=1 for one cycle.
- FSM IDLE to BUSY:
  - In IDLE, an issued R-type with Funct7_i=0000001 sets MulDiv_o=1.
  - If MULDIV_LAT>1, go to BUSY and load counter = MULDIV_LAT-2.
- FSM BUSY:
  - Stall_o=1 and bubbles are registered.
  - If counter==0, go to IDLE; otherwise decrement.
  - Total stall = MULDIV_LAT-1 cycles.
- Flush_i in BUSY: go to IDLE next cycle and clear the counter; the bubble still registers that cycle.
- Priority: reset > Flush_i > BUSY > Hazard_i > decode.
- Hazard_i in BUSY is ignored because BUSY already bubbles.
- Valid_i=0 registers a bubble and never raises Illegal_o.
- Reset mid-BUSY: return to IDLE immediately; Stall_o drops the same cycle the reset is sampled.

Optional Feature:
CTRL_MULDIV_EN
- Defined: M-extension decode and the BUSY FSM as above.
- Undefined: no FSM and no counter. Stall_o and MulDiv_o are tied 0. R-type with Funct7_i=0000001 is treated as illegal: bubble plus an Illegal_o pulse.

Test Plan:
- Reset held 2 cycles, then Valid_i=1, Op=0000011 -> next cycle RW=1 M2R=1 MR=1 ALUOp=00 ALUSrc=1 Valid_o=1.
- Op=0110011, Funct7=0000001, MULDIV_LAT=4, macro on -> MulDiv_o=1 for 1 cycle; Stall_o=1 for exactly 3 cycles; next R-type issues on cycle 5.
- Mul issue, then Flush_i on the 2nd busy cycle -> Stall_o low the following cycle; no further bubbles forced.
- Hazard_i=1 with Op=0110011 -> bubble (all 0, Valid_o=0); Hazard_i=0 next cycle -> R bundle with ALUOp=01.
- Op=1111111, Valid_i=1 -> Illegal_o=1 for one cycle with a bubble. Same stimulus with Valid_i=0 -> Illegal_o stays 0.
- Macro off, Funct7=0000001 R-type -> Illegal_o=1 and Stall_o never asserts. Separately, rst_i=0 mid-BUSY (macro on) -> all outputs 0 after the edge.

Source files
------------

// File: rtl/control_pipe.sv
// Registered ID-stage control decoder driving the ID/EX bundle, with bubble insertion and illegal-opcode flagging.
// Optional macro CTRL_MULDIV_EN enables M-extension decode and the busy FSM that stalls the front end.
module control_pipe #(
   parameter int MULDIV_LAT = 4,
   parameter int CNT_W      = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       Valid_i,
   input  logic [6:0] Op_i,
   input  logic [6:0] Funct7_i,
   input  logic       Hazard_i,
   input  logic       Flush_i,
   output logic       RegWrite_o,
   output logic       MemtoReg_o,
   output logic       MemRead_o,
   output logic       MemWrite_o,
   output logic [1:0] ALUOp_o,
   output logic       ALUSrc_o,
   output logic       Branch_o,
   output logic       Jump_o,
   output logic       MulDiv_o,
   output logic       Valid_o,
   output logic       Stall_o,
   output logic       Illegal_o
);

   // bundle order: RegWrite, MemtoReg, MemRead, MemWrite, ALUOp[1:0], ALUSrc, Branch, Jump
   logic [8:0] bundle_d, bundle_q;
   logic       known_d;
   logic       is_md_d;
   logic       issue_d;
   logic       valid_q;
   logic       illegal_q;

   always_comb begin
      bundle_d = '0;
      known_d  = 1'b1;
      case (Op_i)
         7'b0110011: bundle_d = 9'b1000_01_000;
         7'b0010011: bundle_d = 9'b1000_10_100;
         7'b0000011: bundle_d = 9'b1110_00_100;
         7'b0100011: bundle_d = 9'b0001_00_100;
         7'b1100011: bundle_d = 9'b0000_11_010;
         7'b1101111,
         7'b1100111: bundle_d = 9'b1000_00_101;
         7'b0110111,
         7'b0010111: bundle_d = 9'b1000_00_100;
         default:    known_d  = 1'b0;
      endcase
      is_md_d = (Op_i == 7'b0110011) && (Funct7_i == 7'b0000001);
      issue_d = Valid_i && !Hazard_i && !Flush_i;
   end

`ifdef CTRL_MULDIV_EN
   // state | meaning
   // IDLE  | decoding and issuing normally
   // BUSY  | mul/div occupying EX; front end stalled, bubbles issued
   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             muldiv_q;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bundle_q  <= '0;
         valid_q   <= 1'b0;
         muldiv_q  <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         bundle_q  <= '0;
         valid_q   <= 1'b0;
         muldiv_q  <= 1'b0;
         illegal_q <= 1'b0;
         if (Flush_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
         end else if (state_q == BUSY) begin
            if (cnt_q == '0) state_q <= IDLE;
            else             cnt_q   <= cnt_q - 1'b1;
         end else if (issue_d) begin
            if (!known_d) begin
               illegal_q <= 1'b1;
            end else begin
               bundle_q <= bundle_d;
               valid_q  <= 1'b1;
               if (is_md_d) begin
                  muldiv_q <= 1'b1;
                  // counter starts at LAT-2 so the stall spans LAT-1 cycles
                  if (MULDIV_LAT > 1) begin
                     state_q <= BUSY;
                     cnt_q   <= CNT_W'(MULDIV_LAT - 2);
                  end
               end
            end
         end
      end
   end

   assign Stall_o  = (state_q == BUSY);
   assign MulDiv_o = muldiv_q;
`else
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         bundle_q  <= '0;
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         bundle_q  <= '0;
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
         if (issue_d) begin
            // without M support a mul/div encoding is just another unknown instruction
            if (!known_d || is_md_d) begin
               illegal_q <= 1'b1;
            end else begin
               bundle_q <= bundle_d;
               valid_q  <= 1'b1;
            end
         end
      end
   end

   assign Stall_o  = 1'b0;
   assign MulDiv_o = 1'b0;
`endif

   assign {RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUOp_o,
           ALUSrc_o, Branch_o, Jump_o} = bundle_q;
   assign Valid_o   = valid_q;
   assign Illegal_o = illegal_q;

endmodule

// File: tb/tb_control_pipe.sv
// Self-checking bench for control_pipe: directed vector table, hand-written multi-cycle sequences, and
// randomized stimulus against a cycle-level reference model. Works with CTRL_MULDIV_EN defined or not.
module tb_control_pipe;

   localparam int LAT = 4;
`ifdef CTRL_MULDIV_EN
   localparam bit MD_ON = 1'b1;
`else
   localparam bit MD_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       valid_i = 1'b0;
   logic [6:0] op_i = '0;
   logic [6:0] f7_i = '0;
   logic       hz_i = 1'b0;
   logic       fl_i = 1'b0;
   logic       rw, m2r, mr, mw, asrc, br, jmp, md, vo, st, ill;
   logic [1:0] aluop;

   int n_pass = 0;
   int n_total = 0;
   int busy_left = 0;

   always #5 clk = ~clk;

   control_pipe #(.MULDIV_LAT(LAT), .CNT_W(4)) dut (
      .clk_i(clk), .rst_i(rst), .Valid_i(valid_i), .Op_i(op_i), .Funct7_i(f7_i),
      .Hazard_i(hz_i), .Flush_i(fl_i),
      .RegWrite_o(rw), .MemtoReg_o(m2r), .MemRead_o(mr), .MemWrite_o(mw),
      .ALUOp_o(aluop), .ALUSrc_o(asrc), .Branch_o(br), .Jump_o(jmp),
      .MulDiv_o(md), .Valid_o(vo), .Stall_o(st), .Illegal_o(ill)
   );

   // {RW,M2R,MR,MW,ALUOp[1:0],ALUSrc,Br,J, MulDiv, Valid, Stall, Illegal}
   logic [12:0] outs;
   assign outs = {rw, m2r, mr, mw, aluop, asrc, br, jmp, md, vo, st, ill};

   typedef struct {
      logic [6:0] op;
      logic [8:0] bundle;
   } dec_t;
   dec_t dec_tab[$];

   typedef struct {
      logic       v;
      logic [6:0] op;
      logic [6:0] f7;
      logic       hz;
      logic       fl;
      logic [12:0] exp;
      string      name;
   } vec_t;
   vec_t vecs[$];

   task automatic check(input string nm, input logic [12:0] got, input logic [12:0] exp);
      n_total++;
      if (got !== exp) $display("FAIL %s: got %b expected %b", nm, got, exp);
      else n_pass++;
   endtask

   function automatic logic [12:0] model_step(input logic v, input logic [6:0] op,
                                              input logic [6:0] f7, input logic hz, input logic fl);
      logic [12:0] e;
      bit          known;
      bit          is_md;
      e = '0;
      if (fl) busy_left = 0;
      else if (busy_left > 0) busy_left--;
      else if (v && !hz) begin
         known = 0;
         foreach (dec_tab[i]) if (dec_tab[i].op == op) begin
            known = 1;
            e[12:4] = dec_tab[i].bundle;
         end
         is_md = (op == 7'h33) && (f7 == 7'h01);
         if (!known || (is_md && !MD_ON)) begin
            e = '0;
            e[0] = 1'b1;
         end else begin
            e[2] = 1'b1;
            if (is_md) begin
               e[3] = 1'b1;
               busy_left = LAT - 1;
            end
         end
      end
      e[1] = (busy_left > 0);
      return e;
   endfunction

   task automatic drive(input logic v, input logic [6:0] op, input logic [6:0] f7,
                        input logic hz, input logic fl);
      valid_i = v; op_i = op; f7_i = f7; hz_i = hz; fl_i = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input logic v, input logic [6:0] op, input logic [6:0] f7,
                      input logic hz, input logic fl, input string nm);
      logic [12:0] e;
      e = model_step(v, op, f7, hz, fl);
      drive(v, op, f7, hz, fl);
      check(nm, outs, e);
   endtask

   task automatic do_reset(input string nm);
      rst = 1'b0;
      drive(0, 7'h00, 7'h00, 0, 0);
      drive(0, 7'h00, 7'h00, 0, 0);
      busy_left = 0;
      check(nm, outs, 13'b0);
      rst = 1'b1;
   endtask

   initial begin
      int stall_cnt;
      logic [6:0] pool[10];
      logic [6:0] f7s[3];

      dec_tab.push_back('{7'b0110011, 9'b1000_01_000});
      dec_tab.push_back('{7'b0010011, 9'b1000_10_100});
      dec_tab.push_back('{7'b0000011, 9'b1110_00_100});
      dec_tab.push_back('{7'b0100011, 9'b0001_00_100});
      dec_tab.push_back('{7'b1100011, 9'b0000_11_010});
      dec_tab.push_back('{7'b1101111, 9'b1000_00_101});
      dec_tab.push_back('{7'b1100111, 9'b1000_00_101});
      dec_tab.push_back('{7'b0110111, 9'b1000_00_100});
      dec_tab.push_back('{7'b0010111, 9'b1000_00_100});

      vecs.push_back('{1, 7'b0000011, 7'h00, 0, 0, 13'b1110_00_100_0_1_0_0, "load"});
      vecs.push_back('{1, 7'b0110011, 7'h00, 1, 0, 13'b0, "hazard_bubble"});
      vecs.push_back('{1, 7'b0110011, 7'h00, 0, 0, 13'b1000_01_000_0_1_0_0, "r_after_hazard"});
      vecs.push_back('{1, 7'b0110011, 7'h20, 0, 0, 13'b1000_01_000_0_1_0_0, "r_sub"});
      vecs.push_back('{1, 7'b0010011, 7'h00, 0, 0, 13'b1000_10_100_0_1_0_0, "itype"});
      vecs.push_back('{1, 7'b0100011, 7'h00, 0, 0, 13'b0001_00_100_0_1_0_0, "store"});
      vecs.push_back('{1, 7'b1100011, 7'h00, 0, 0, 13'b0000_11_010_0_1_0_0, "branch"});
      vecs.push_back('{1, 7'b1101111, 7'h00, 0, 0, 13'b1000_00_101_0_1_0_0, "jal"});
      vecs.push_back('{1, 7'b1100111, 7'h00, 0, 0, 13'b1000_00_101_0_1_0_0, "jalr"});
      vecs.push_back('{1, 7'b0110111, 7'h00, 0, 0, 13'b1000_00_100_0_1_0_0, "lui"});
      vecs.push_back('{1, 7'b0010111, 7'h00, 0, 0, 13'b1000_00_100_0_1_0_0, "auipc"});
      vecs.push_back('{1, 7'b1111111, 7'h00, 0, 0, 13'b0000_00_000_0_0_0_1, "illegal"});
      vecs.push_back('{1, 7'b0000011, 7'h00, 0, 0, 13'b1110_00_100_0_1_0_0, "illegal_one_cycle"});
      vecs.push_back('{0, 7'b1111111, 7'h00, 0, 0, 13'b0, "illegal_invalid"});
      vecs.push_back('{1, 7'b1111111, 7'h00, 1, 0, 13'b0, "illegal_hazard"});
      vecs.push_back('{1, 7'b0000011, 7'h00, 0, 1, 13'b0, "flush_bubble"});
      vecs.push_back('{0, 7'b0110011, 7'h00, 0, 0, 13'b0, "invalid_bubble"});

      rst = 1'b0;
      drive(1, 7'b0110011, 7'h00, 0, 0);
      drive(1, 7'b0110011, 7'h00, 0, 0);
      check("reset_state", outs, 13'b0);
      rst = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].v, vecs[i].op, vecs[i].f7, vecs[i].hz, vecs[i].fl);
         check(vecs[i].name, outs, vecs[i].exp);
      end

      // mul/div issue followed by a held R-type stream
      do_reset("reset_before_md");
      stall_cnt = 0;
      cyc(1, 7'b0110011, 7'h01, 0, 0, "md_issue");
      if (MD_ON) check("md_issue_exact", outs, 13'b1000_01_000_1_1_1_0);
      else       check("md_illegal_off", outs, 13'b0000_00_000_0_0_0_1);
      if (st) stall_cnt++;
      for (int k = 0; k < 5; k++) begin
         cyc(1, 7'b0110011, 7'h00, 0, 0, $sformatf("md_follow_%0d", k));
         if (st) stall_cnt++;
      end
      n_total++;
      if (stall_cnt != (MD_ON ? LAT - 1 : 0))
         $display("FAIL md_stall_len: got %0d expected %0d", stall_cnt, MD_ON ? LAT - 1 : 0);
      else n_pass++;

      // flush on the second busy cycle
      do_reset("reset_before_flush");
      cyc(1, 7'b0110011, 7'h01, 0, 0, "flush_md_issue");
      cyc(1, 7'b0010011, 7'h00, 1, 0, "flush_busy1_hazard");
      cyc(1, 7'b0010011, 7'h00, 0, 1, "flush_busy2");
      check("flush_stall_low", {12'b0, st}, 13'b0);
      cyc(1, 7'b0010011, 7'h00, 0, 0, "flush_resume");
      if (MD_ON) check("flush_resume_exact", outs, 13'b1000_10_100_0_1_0_0);

      // reset sampled while busy
      do_reset("reset_before_midbusy");
      cyc(1, 7'b0110011, 7'h01, 0, 0, "midbusy_issue");
      cyc(1, 7'b0110011, 7'h00, 0, 0, "midbusy_1");
      rst = 1'b0;
      drive(1, 7'b0110011, 7'h00, 0, 0);
      busy_left = 0;
      check("midbusy_reset", outs, 13'b0);
      rst = 1'b1;
      cyc(1, 7'b0000011, 7'h00, 0, 0, "after_midbusy_reset");

      // randomized run against the model
      pool = '{7'b0110011, 7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
               7'b1100011, 7'b1101111, 7'b0110111, 7'b1111111, 7'b0000000};
      f7s = '{7'h00, 7'h01, 7'h20};
      for (int k = 0; k < 400; k++) begin
         logic [6:0] rop;
         rop = ($urandom_range(0, 9) == 0) ? 7'($urandom) : pool[$urandom_range(0, 9)];
         cyc($urandom_range(0, 9) < 8, rop, f7s[$urandom_range(0, 2)],
             $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 8, $sformatf("rand_%0d", k));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
